// File: rtl/block_window_loader_if.sv
// ROM read bus between block_window_loader (master) and the song block ROM (slave).
interface block_window_loader_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr_out;
  logic [53:0]       rom_data_in;

  modport master (output rom_addr_out, input rom_data_in);
  modport slave  (input rom_addr_out, output rom_data_in);
endinterface

// File: rtl/block_window_loader.sv
// Sliding window of the 12 earliest unexpired song blocks, refilled from the block ROM.
// Optional macro SKIP_EXPIRED_EN: drop already-expired records at append time (mid-song start).
module block_window_loader #(
  parameter int NUM_BLOCKS  = 256,
  parameter int ADDR_W      = 8,
  parameter int ROM_LATENCY = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [17:0]         curr_time_in,
  input  logic                start_in,
  block_window_loader_if.master rom,
  output logic [17:0]         curr_time_out,
  output logic [11:0][11:0]   block_x_out,
  output logic [11:0][11:0]   block_y_out,
  output logic [11:0][17:0]   block_time_out,
  output logic [11:0]         block_color_out,
  output logic [11:0][2:0]    block_direction_out,
  output logic [11:0][7:0]    block_ID_out,
  output logic [11:0]         slot_valid_out,
  output logic                window_ready_out,
  output logic                song_done_out
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_APPEND = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [ADDR_W:0] NB  = (ADDR_W+1)'(NUM_BLOCKS);
  localparam logic [2:0]      LAT = 3'(ROM_LATENCY);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   next_addr_q, next_addr_d;
  logic [3:0]        count_q, count_d;
  logic [2:0]        lat_q, lat_d;
  logic [53:0]       rec_q, rec_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [11:0][53:0] slot_q, slot_d;
  logic [11:0]       valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [17:0]       time_q;
  logic              active_s, evict_s, keep_s;

  assign active_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                    (state_q == ST_APPEND) || (state_q == ST_RUN);

  // Next-state: head eviction first, then the FSM step that may append into the shifted window.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    lat_d       = lat_q;
    rec_d       = rec_q;
    rom_addr_d  = rom_addr_q;
    slot_d      = slot_q;
    valid_d     = valid_q;
    evict_s     = 1'b0;
    keep_s      = 1'b1;
    if (start_in) begin
      state_d     = ST_ISSUE;
      next_addr_d = '0;
      count_d     = 4'd0;
      lat_d       = 3'd0;
      rom_addr_d  = '0;
      slot_d      = '0;
      valid_d     = 12'd0;
    end else begin
      evict_s = active_s && valid_q[0] && (slot_q[0][53:36] <= curr_time_in);
      if (evict_s) begin
        slot_d  = {54'd0, slot_q[11:1]};
        valid_d = {1'b0, valid_q[11:1]};
        count_d = count_q - 4'd1;
      end else begin
        slot_d  = slot_q;
        valid_d = valid_q;
        count_d = count_q;
      end
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ISSUE: begin
          rom_addr_d = next_addr_q[ADDR_W-1:0];
          lat_d      = LAT;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          lat_d = lat_q - 3'd1;
          if (lat_q <= 3'd1) begin
            rec_d   = rom.rom_data_in;
            state_d = ST_APPEND;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_APPEND: begin
`ifdef SKIP_EXPIRED_EN
          keep_s = (rec_q[53:36] > curr_time_in);
`else
          keep_s = 1'b1;
`endif
          // count_d already reflects a same-cycle eviction, so the record lands behind the new tail.
          if (keep_s) begin
            slot_d[count_d]  = rec_q;
            valid_d[count_d] = 1'b1;
            count_d          = count_d + 4'd1;
          end else begin
            count_d = count_d;
          end
          next_addr_d = next_addr_q + (ADDR_W+1)'(1);
          if ((count_d < 4'd12) && (next_addr_d < NB)) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if ((count_d < 4'd12) && (next_addr_q < NB)) begin
            state_d = ST_ISSUE;
          end else if ((next_addr_q == NB) && (count_d == 4'd0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_RUN) && ((next_addr_d == NB) || (count_d == 4'd12));
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      count_q     <= 4'd0;
      lat_q       <= 3'd0;
      rec_q       <= 54'd0;
      rom_addr_q  <= '0;
      slot_q      <= '0;
      valid_q     <= 12'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      time_q      <= 18'd0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      lat_q       <= lat_d;
      rec_q       <= rec_d;
      rom_addr_q  <= rom_addr_d;
      slot_q      <= slot_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      time_q      <= (state_d == ST_IDLE) ? 18'd0 : curr_time_in;
    end
  end

  assign rom.rom_addr_out   = rom_addr_q;
  assign curr_time_out      = time_q;
  assign slot_valid_out     = valid_q;
  assign window_ready_out   = ready_q;
  assign song_done_out      = done_q;

  for (genvar g = 0; g < 12; g++) begin : g_slot
    assign block_time_out[g]      = slot_q[g][53:36];
    assign block_x_out[g]         = slot_q[g][35:24];
    assign block_y_out[g]         = slot_q[g][23:12];
    assign block_color_out[g]     = slot_q[g][11];
    assign block_direction_out[g] = slot_q[g][10:8];
    assign block_ID_out[g]        = slot_q[g][7:0];
  end
endmodule

// File: tb/tb_block_window_loader.sv
// Randomized scoreboard bench for block_window_loader against a queue-based window model.
module tb_block_window_loader;
  localparam int NB = 256;
  localparam int L  = 2;

  typedef struct packed {
    logic [11:0][53:0] slots;
    logic [11:0]       valid;
    logic              ready;
    logic              done;
    logic [17:0]       ct;
    logic [7:0]        addr;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [17:0] ctime = 18'd0;
  logic [17:0] curr_time_out;
  logic [11:0][11:0] bx, by;
  logic [11:0][17:0] bt;
  logic [11:0] bc;
  logic [11:0][2:0] bd;
  logic [11:0][7:0] bid;
  logic [11:0] valid;
  logic ready, done;

  block_window_loader_if #(.ADDR_W(8)) rif ();

  block_window_loader #(.NUM_BLOCKS(NB), .ADDR_W(8), .ROM_LATENCY(L)) dut (
    .clk_in(clk), .rst_in(rst), .curr_time_in(ctime), .start_in(start), .rom(rif),
    .curr_time_out(curr_time_out), .block_x_out(bx), .block_y_out(by), .block_time_out(bt),
    .block_color_out(bc), .block_direction_out(bd), .block_ID_out(bid),
    .slot_valid_out(valid), .window_ready_out(ready), .song_done_out(done)
  );

  always #5 clk = ~clk;

  logic [53:0] rom_mem [NB];
  // ROM with L-1 register stages between address and data.
  always @(posedge clk) rif.rom_data_in <= rom_mem[rif.rom_addr_out];

  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];

  logic [53:0] m_win[$];
  int m_na = 0;
  int m_pend = -1;
  bit m_running = 1'b0;
  bit m_done = 1'b0;
  logic [7:0] m_addr = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Window model: a read is requested whenever there is room; its record arrives L+2 edges later.
  task automatic step_model(input bit st, input logic [17:0] ct);
    snap_t s;
    logic [53:0] rec;
    bit keep;
    if (st) begin
      m_win.delete();
      m_na = 0; m_pend = L + 2; m_running = 1'b1; m_done = 1'b0; m_addr = 8'd0;
    end else if (m_running && !m_done) begin
      if (m_win.size() > 0 && m_win[0][53:36] <= ct) void'(m_win.pop_front());
      if (m_pend == 1) begin
        rec = rom_mem[m_na];
        keep = 1'b1;
`ifdef SKIP_EXPIRED_EN
        keep = (rec[53:36] > ct);
`endif
        if (keep) m_win.push_back(rec);
        m_na++;
        m_pend = -1;
        if (m_win.size() < 12 && m_na < NB) m_pend = L + 2;
      end else if (m_pend > 1) begin
        m_pend--;
        if (m_pend == L + 1) m_addr = 8'(m_na);
      end else begin
        if (m_win.size() < 12 && m_na < NB) m_pend = L + 2;
        else if (m_na == NB && m_win.size() == 0) m_done = 1'b1;
      end
    end
    s.slots = '0;
    for (int i = 0; i < m_win.size(); i++) s.slots[i] = m_win[i];
    s.valid = 12'((1 << m_win.size()) - 1);
    s.ready = m_running && !m_done && (m_pend == -1) && (m_na == NB || m_win.size() == 12);
    s.done  = m_done;
    s.ct    = m_running ? ct : 18'd0;
    s.addr  = m_addr;
    exp_q.push_back(s);
  endtask

  task automatic cyc(input bit st, input logic [17:0] ct);
    @(negedge clk);
    start = st;
    ctime = ct;
    @(posedge clk);
    step_model(st, ct);
  endtask

  // Monitor: compare DUT outputs just after each edge with the oldest pending expectation.
  always @(posedge clk) begin
    snap_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < 12; i++)
        chk($sformatf("slot%0d", i), 64'({bt[i], bx[i], by[i], bc[i], bd[i], bid[i]}), 64'(e.slots[i]));
      chk("slot_valid", 64'(valid), 64'(e.valid));
      chk("window_ready", 64'(ready), 64'(e.ready));
      chk("song_done", 64'(done), 64'(e.done));
      chk("curr_time_out", 64'(curr_time_out), 64'(e.ct));
      chk("rom_addr", 64'(rif.rom_addr_out), 64'(e.addr));
    end
  end

  initial begin
    logic [17:0] t;
    for (int i = 0; i < NB; i++)
      rom_mem[i] = {18'(10 * (i + 1)), 12'($urandom), 12'($urandom), 1'($urandom), 3'($urandom), 8'(i)};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 18'd0);

    // Cold fill: 12 records, L+2 cycles each.
    cyc(1'b1, 18'd0);
    repeat (48) cyc(1'b0, 18'd0);
    #1;
    chk("cold_valid", 64'(valid), 64'hFFF);
    chk("cold_ready", 64'(ready), 64'd1);
    chk("cold_t0", 64'(bt[0]), 64'd10);
    chk("cold_t11", 64'(bt[11]), 64'd120);

    cyc(1'b0, 18'd10);
    #1;
    chk("evict_t0", 64'(bt[0]), 64'd20);
    chk("evict_valid", 64'(valid), 64'h7FF);
    repeat (4) cyc(1'b0, 18'd10);
    #1;
    chk("refill_t11", 64'(bt[11]), 64'd130);
    chk("refill_valid", 64'(valid), 64'hFFF);

    // Abort a read while it is in flight.
    repeat (3) cyc(1'b0, 18'd20);
    cyc(1'b1, 18'd20);
    #1;
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_addr", 64'(rif.rom_addr_out), 64'd0);

    // Random ramp of song time until the song is exhausted.
    t = 18'd0;
    for (int n = 0; n < 8000 && !m_done; n++) begin
      t = t + 18'($urandom_range(0, 4));
      cyc(1'b0, t);
    end
    checks++;
    if (!m_done) begin
      errors++;
      $display("FAIL drain_timeout: model song not done within cycle budget");
    end
    repeat (2) cyc(1'b0, t);
    #1;
    chk("end_done", 64'(done), 64'd1);
    chk("end_valid", 64'(valid), 64'd0);

    // Mid-song start: records up to time 50 expire either at append or at the head.
    cyc(1'b1, 18'd55);
    repeat (80) cyc(1'b0, 18'd55);
    #1;
    chk("mid_t0", 64'(bt[0]), 64'd60);
    chk("mid_valid", 64'(valid), 64'hFFF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
